rf_mp: RTL and testbench

- Parametrised successor to the pipeline's 2R/1W general-purpose register file.
- Generalised data/address width and configurable $gp/$sp reset values.
- Adds a second write port, same-cycle write-to-read bypass, and a multi-cycle clear-sweep FSM.
- Sits in the ID stage of the pipelined core. Writes come from WB (and a secondary port for multi-result ops); reads feed ID operand muxes.

---
 rtl/rf_mp.sv | 126 ++++++++++++
 tb/tb_rf_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_mp.sv
// rf_mp: 2R/2W register file with bypass, clear-sweep FSM and optional parity (macro RF_PARITY_EN)
module rf_mp #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                GP_IDX  = 28,
    parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
    parameter int                SP_IDX  = 29,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_2ffc
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              We0,
    input  logic [ADDR_W-1:0] A3_0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] A3_1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              Clr,
    output logic              Busy,
    output logic              WrDrop,
    input  logic              ParInj,
    output logic              ParErr1,
    output logic              ParErr2
);
    localparam int DEPTH = 2**ADDR_W;
    localparam bit GP_OK = (GP_IDX > 0) && (GP_IDX < DEPTH);
    localparam bit SP_OK = (SP_IDX > 0) && (SP_IDX < DEPTH);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wrdrop_q, wrdrop_d;
    logic              idle, w0, w1, h10, h11, h20, h21;

    function automatic logic [DATA_W-1:0] rst_val(input logic [ADDR_W-1:0] i);
        return (GP_OK && int'(i) == GP_IDX) ? GP_INIT :
               (SP_OK && int'(i) == SP_IDX) ? SP_INIT : '0;
    endfunction

    assign idle   = state_q == IDLE;
    assign w0     = We0 && |A3_0;
    assign w1     = We1 && |A3_1;
    assign h10    = idle && |A1 && w0 && A3_0 == A1;
    assign h11    = idle && |A1 && w1 && A3_1 == A1;
    assign h20    = idle && |A2 && w0 && A3_0 == A2;
    assign h21    = idle && |A2 && w1 && A3_1 == A2;
    assign Busy   = state_q == SWEEP;
    assign WrDrop = wrdrop_q;

    // Read ports: zero-latency bypass from the winning write port, port 1 over port 0
    always_comb begin
        RD1 = ~|A1 ? '0 : h11 ? WD1 : h10 ? WD0 : mem_q[A1];
        RD2 = ~|A2 ? '0 : h21 ? WD1 : h20 ? WD0 : mem_q[A2];
    end

`ifdef RF_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;

    // Parity check only on stored reads; bypassed data never went through storage
    always_comb begin
        ParErr1 = |A1 && !(h10 || h11) && ((^mem_q[A1]) != par_q[A1]);
        ParErr2 = |A2 && !(h20 || h21) && ((^mem_q[A2]) != par_q[A2]);
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = ParInj;
    assign ParErr1 = 1'b0;
    assign ParErr2 = 1'b0;
`endif

    // Next state: commit writes in IDLE (port 1 applied last so it wins), sweep one entry per cycle otherwise
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        wrdrop_d = !idle && (w0 || w1);
`ifdef RF_PARITY_EN
        par_d    = par_q;
`endif
        if (idle) begin
            if (w0) mem_d[A3_0] = WD0;
            if (w1) mem_d[A3_1] = WD1;
`ifdef RF_PARITY_EN
            if (w0) par_d[A3_0] = (^WD0) ^ ParInj;
            if (w1) par_d[A3_1] = (^WD1) ^ ParInj;
`endif
            state_d = Clr ? SWEEP : IDLE;
            cnt_d   = Clr ? '0 : cnt_q;
        end else begin
            mem_d[cnt_q] = rst_val(cnt_q);
`ifdef RF_PARITY_EN
            par_d[cnt_q] = ^rst_val(cnt_q);
`endif
            cnt_d   = cnt_q + 1'b1;
            state_d = &cnt_q ? IDLE : SWEEP;
        end
    end

    // State registers with asynchronous reset to the power-on register image
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wrdrop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= rst_val(ADDR_W'(i));
`ifdef RF_PARITY_EN
            for (int i = 0; i < DEPTH; i++) par_q[i] <= ^rst_val(ADDR_W'(i));
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wrdrop_q <= wrdrop_d;
            mem_q    <= mem_d;
`ifdef RF_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: randomized self-checking bench for rf_mp against a behavioural register-file model
module tb_rf_mp;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  A1 = '0, A2 = '0, A3_0 = '0, A3_1 = '0;
    logic [31:0] RD1, RD2, WD0 = '0, WD1 = '0;
    logic        We0 = 1'b0, We1 = 1'b0, Clr = 1'b0, ParInj = 1'b0;
    logic        Busy, WrDrop, ParErr1, ParErr2;

    int total = 0;
    int bad = 0;

    logic [31:0] m [32];
    bit          pbad [32];
    bit          sweeping;
    int          sidx;
    bit          drop;

    rf_mp dut (
        .Clk(Clk), .Rst_n(Rst_n), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .We0(We0), .A3_0(A3_0), .WD0(WD0), .We1(We1), .A3_1(A3_1), .WD1(WD1),
        .Clr(Clr), .Busy(Busy), .WrDrop(WrDrop), .ParInj(ParInj),
        .ParErr1(ParErr1), .ParErr2(ParErr2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] rstv(input int i);
        return i == 28 ? 32'h0000_1800 : i == 29 ? 32'h0000_2ffc : 32'h0;
    endfunction

    function automatic bit bypassed(input logic [4:0] a);
        return !sweeping && a != 0 &&
               ((We1 && A3_1 == a) || (We0 && A3_0 == a));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!sweeping && We1 && A3_1 == a) return WD1;
        if (!sweeping && We0 && A3_0 == a) return WD0;
        return m[a];
    endfunction

    function automatic bit exp_perr(input logic [4:0] a);
`ifdef RF_PARITY_EN
        return a != 0 && !bypassed(a) && pbad[a];
`else
        return a != a;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m[i] = rstv(i);
            pbad[i] = 0;
        end
        sweeping = 0;
        sidx = 0;
        drop = 0;
    endtask

    task automatic quiet();
        We0 = 0; We1 = 0; Clr = 0; ParInj = 0;
    endtask

    task automatic tick();
        bit w0, w1;
        w0 = We0 && A3_0 != 0;
        w1 = We1 && A3_1 != 0;
        drop = sweeping && (w0 || w1);
        if (!sweeping) begin
            if (w0) begin m[A3_0] = WD0; pbad[A3_0] = ParInj; end
            if (w1) begin m[A3_1] = WD1; pbad[A3_1] = ParInj; end
            if (Clr) begin sweeping = 1; sidx = 0; end
        end else begin
            m[sidx] = rstv(sidx);
            pbad[sidx] = 0;
            sidx++;
            if (sidx == 32) sweeping = 0;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        Rst_n = 0;
        model_reset();
        #3;
        if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        total++;
        if (WrDrop !== 1'b0) begin bad++; $display("FAIL reset_wrdrop: got %b want 0", WrDrop); end
        total++;
        @(posedge Clk);
        #1;
        Rst_n = 1;
        A1 = 28; A2 = 29;
        #2;
        if (RD1 !== 32'h0000_1800) begin bad++; $display("FAIL reset_gp: got %h want 00001800", RD1); end
        total++;
        if (RD2 !== 32'h0000_2ffc) begin bad++; $display("FAIL reset_sp: got %h want 00002ffc", RD2); end
        total++;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            #1;
            if (RD1 !== rstv(i)) begin bad++; $display("FAIL reset_reg%0d: got %h want %h", i, RD1, rstv(i)); end
            total++;
        end
    endtask

    task automatic test_bypass();
        quiet();
        We0 = 1; A3_0 = 7; WD0 = 32'hDEAD_BEEF; A1 = 7;
        #2;
        if (RD1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_same_cycle: got %h want deadbeef", RD1); end
        total++;
        tick();
        We0 = 0;
        #2;
        if (RD1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_stored: got %h want deadbeef", RD1); end
        total++;
    endtask

    task automatic test_dual_write();
        quiet();
        We0 = 1; We1 = 1; A3_0 = 9; A3_1 = 9; WD0 = 1; WD1 = 2; A1 = 9; A2 = 9;
        #2;
        if (RD1 !== 32'd2) begin bad++; $display("FAIL dual_bypass: got %h want 2", RD1); end
        total++;
        tick();
        quiet();
        #2;
        if (RD2 !== 32'd2) begin bad++; $display("FAIL dual_stored: got %h want 2", RD2); end
        total++;
        We0 = 1; A3_0 = 0; WD0 = 5; A1 = 0;
        #2;
        if (RD1 !== 32'd0) begin bad++; $display("FAIL zero_bypass: got %h want 0", RD1); end
        total++;
        tick();
        quiet();
        #2;
        if (RD1 !== 32'd0) begin bad++; $display("FAIL zero_stored: got %h want 0", RD1); end
        total++;
        if (WrDrop !== 1'b0) begin bad++; $display("FAIL zero_nodrop: got %b want 0", WrDrop); end
        total++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            We0 = 1'($urandom); We1 = 1'($urandom);
            A3_0 = 5'($urandom_range(0, 15)); A3_1 = 5'($urandom_range(0, 15));
            WD0 = $urandom; WD1 = $urandom;
            A1 = 5'($urandom_range(0, 15)); A2 = ($urandom_range(0, 3) == 0) ? A3_1 : 5'($urandom_range(0, 31));
            ParInj = $urandom_range(0, 7) == 0;
            Clr = 0;
            #2;
            if (RD1 !== exp_rd(A1)) begin bad++; $display("FAIL rand_rd1 c=%0d a=%0d: got %h want %h", c, A1, RD1, exp_rd(A1)); end
            total++;
            if (RD2 !== exp_rd(A2)) begin bad++; $display("FAIL rand_rd2 c=%0d a=%0d: got %h want %h", c, A2, RD2, exp_rd(A2)); end
            total++;
            if (ParErr1 !== exp_perr(A1)) begin bad++; $display("FAIL rand_perr1 c=%0d: got %b want %b", c, ParErr1, exp_perr(A1)); end
            total++;
            if (ParErr2 !== exp_perr(A2)) begin bad++; $display("FAIL rand_perr2 c=%0d: got %b want %b", c, ParErr2, exp_perr(A2)); end
            total++;
            tick();
        end
        quiet();
    endtask

    task automatic test_sweep();
        int busy_cycles;
        quiet();
        We0 = 1; A3_0 = 4; WD0 = 3;
        tick();
        We0 = 1; A3_0 = 10; WD0 = 32'h1234_5678; Clr = 1;
        tick();
        quiet();
        busy_cycles = 0;
        for (int c = 0; c < 40 && Busy === 1'b1; c++) begin
            busy_cycles++;
            A1 = 5'($urandom); A2 = 5'($urandom);
            Clr = $urandom_range(0, 3) == 0;
            We0 = (c == 5) || ($urandom_range(0, 3) == 0);
            A3_0 = (c == 5) ? 5'd4 : 5'($urandom);
            WD0 = $urandom;
            We1 = 1'($urandom); A3_1 = 5'($urandom); WD1 = $urandom;
            #2;
            if (RD1 !== exp_rd(A1)) begin bad++; $display("FAIL sweep_rd1 c=%0d a=%0d: got %h want %h", c, A1, RD1, exp_rd(A1)); end
            total++;
            if (RD2 !== exp_rd(A2)) begin bad++; $display("FAIL sweep_rd2 c=%0d a=%0d: got %h want %h", c, A2, RD2, exp_rd(A2)); end
            total++;
            tick();
            if (WrDrop !== drop) begin bad++; $display("FAIL sweep_wrdrop c=%0d: got %b want %b", c, WrDrop, drop); end
            total++;
            if (Busy !== sweeping) begin bad++; $display("FAIL sweep_busy c=%0d: got %b want %b", c, Busy, sweeping); end
            total++;
        end
        quiet();
        if (busy_cycles != 32) begin bad++; $display("FAIL sweep_length: got %0d want 32", busy_cycles); end
        total++;
        tick();
        A1 = 4; A2 = 29;
        #2;
        if (RD1 !== 32'd0) begin bad++; $display("FAIL sweep_reg4: got %h want 0", RD1); end
        total++;
        if (RD2 !== 32'h0000_2ffc) begin bad++; $display("FAIL sweep_reg29: got %h want 00002ffc", RD2); end
        total++;
    endtask

    task automatic test_sweep_reset();
        quiet();
        We0 = 1; A3_0 = 12; WD0 = 32'h55;
        tick();
        quiet();
        Clr = 1;
        tick();
        Clr = 0;
        for (int c = 0; c < 10; c++) tick();
        Rst_n = 0;
        model_reset();
        #1;
        if (Busy !== 1'b0) begin bad++; $display("FAIL midsweep_reset_busy: got %b want 0", Busy); end
        total++;
        A1 = 12;
        #1;
        if (RD1 !== 32'd0) begin bad++; $display("FAIL midsweep_reset_reg12: got %h want 0", RD1); end
        total++;
        @(posedge Clk);
        #2;
        Rst_n = 1;
        tick();
        if (Busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got %b want 0", Busy); end
        total++;
    endtask

    task automatic test_parity();
        bit want;
        quiet();
        We0 = 1; A3_0 = 3; WD0 = 32'h0000_0007; ParInj = 1;
        tick();
        quiet();
        A1 = 3;
        want = exp_perr(3);
        #2;
        if (ParErr1 !== want) begin bad++; $display("FAIL parity_inject: got %b want %b", ParErr1, want); end
        total++;
        We0 = 1; A3_0 = 3; WD0 = 32'h0000_0007; ParInj = 0;
        tick();
        quiet();
        #2;
        if (ParErr1 !== 1'b0) begin bad++; $display("FAIL parity_clean: got %b want 0", ParErr1); end
        total++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_random();
        test_sweep();
        test_sweep_reset();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
